// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the word-indexed PC, absorbs the one-cycle
// instruction-memory latency and hands {instr, pc} pairs to decode via valid/ready.
module fetch_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 40,
    parameter int RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_L = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE_L   = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [1:0]        count_r, count_s;
    logic [DATA_W-1:0] instr0_r, instr1_r, instr0_s, instr1_s;
    logic [ADDR_W-1:0] pc0_r, pc1_r, pc0_s, pc1_s;
    logic              pop_s;
    logic [2:0]        occ_s;
    logic              issue_s;

    // Issue only while the buffer plus the in-flight read leaves room after this cycle's pop.
    always_comb begin
        pop_s   = (count_r != 2'd0) && out_ready;
        occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s = !redirect_valid && (state_r == ST_RUN) &&
                  (fetch_pc_r < DEPTH_L) && (occ_s < 3'd2);
    end

    // Next FSM state; redirect overrides everything.
    always_comb begin
        state_s = state_r;
        if (redirect_valid) begin
            state_s = (redirect_pc < DEPTH_L) ? ST_RUN : ST_DRAIN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (fetch_pc_r >= DEPTH_L) state_s = ST_DRAIN;
                    else                       state_s = ST_RUN;
                end
                ST_DRAIN: begin
                    if ((count_r == 2'd0) && !inflight_r) state_s = ST_HALT;
                    else                                  state_s = ST_DRAIN;
                end
                ST_HALT: state_s = ST_HALT;
                default: state_s = ST_RUN;
            endcase
        end
    end

    // Two-entry buffer next values: entry 0 is the head; a pop shifts entry 1 down.
    always_comb begin
        count_s  = count_r;
        instr0_s = instr0_r;
        instr1_s = instr1_r;
        pc0_s    = pc0_r;
        pc1_s    = pc1_r;
        if (redirect_valid) begin
            count_s = 2'd0;
        end else begin
            case ({inflight_r, pop_s})
                2'b01: begin
                    instr0_s = instr1_r;
                    pc0_s    = pc1_r;
                    count_s  = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        instr0_s = imem_instr;
                        pc0_s    = inflight_pc_r;
                    end else begin
                        instr1_s = imem_instr;
                        pc1_s    = inflight_pc_r;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        instr0_s = imem_instr;
                        pc0_s    = inflight_pc_r;
                    end else begin
                        instr0_s = instr1_r;
                        pc0_s    = pc1_r;
                        instr1_s = imem_instr;
                        pc1_s    = inflight_pc_r;
                    end
                end
                default: count_s = count_r;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_RUN;
            fetch_pc_r    <= RESET_L;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            count_r       <= 2'd0;
            instr0_r      <= {DATA_W{1'b0}};
            instr1_r      <= {DATA_W{1'b0}};
            pc0_r         <= {ADDR_W{1'b0}};
            pc1_r         <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ONE_L;
            end
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
            end
            count_r  <= count_s;
            instr0_r <= instr0_s;
            instr1_r <= instr1_s;
            pc0_r    <= pc0_s;
            pc1_r    <= pc1_s;
        end
    end

    assign imem_addr = fetch_pc_r;
    assign out_valid = (count_r != 2'd0);
    assign out_instr = instr0_r;
    assign out_pc    = pc0_r;
    assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus hand-written
// sequences for run-to-halt, out-of-range redirect and asynchronous reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [10:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rv;
        logic [10:0] rpc;
        logic        rdy;
        logic        ev;
        logic [10:0] epc;
        logic [10:0] eaddr;
    } vec_t;

    vec_t vq[$];

    fetch_ctrl #(.ADDR_W(11), .DATA_W(32), .MEM_DEPTH(40), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [10:0] a);
        return 32'hC0DE_0000 ^ {21'd0, a} ^ ({21'd0, a} << 20);
    endfunction

    // Synchronous instruction memory: data valid the cycle after the address.
    always @(posedge clk) imem_instr <= instr_of(imem_addr);

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rv, input logic [10:0] rpc, input logic rdy,
                           input logic ev, input logic [10:0] epc, input logic [10:0] eaddr);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    // Leaves the bench at a falling edge with rst low: the current cycle is cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 11'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //      rv    rpc     rdy   ev    epc     eaddr
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd0);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd1);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd0,  11'd2);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd1,  11'd3);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd2,  11'd4);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd3,  11'd5);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd4,  11'd6);
        add_vec(1'b0, 11'd0,  1'b0, 1'b1, 11'd5,  11'd7);
        add_vec(1'b1, 11'd20, 1'b0, 1'b1, 11'd5,  11'd7);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd20);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd21);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd20, 11'd22);
        add_vec(1'b1, 11'd10, 1'b1, 1'b1, 11'd21, 11'd23);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd10);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd11);
        add_vec(1'b1, 11'd30, 1'b1, 1'b1, 11'd10, 11'd12);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd30);
        add_vec(1'b0, 11'd0,  1'b1, 1'b0, 11'd0,  11'd31);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd30, 11'd32);
        add_vec(1'b0, 11'd0,  1'b1, 1'b1, 11'd31, 11'd33);

        // Table: backpressure, redirect with a full buffer, redirect with pop.
        do_reset();
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        for (int k = 0; k < vq.size(); k++) begin
            redirect_valid = vq[k].rv;
            redirect_pc    = vq[k].rpc;
            out_ready      = vq[k].rdy;
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vq[k].ev));
            chk($sformatf("vec%0d_addr", k), 32'(imem_addr), 32'(vq[k].eaddr));
            chk($sformatf("vec%0d_halted", k), 32'(halted), 32'd0);
            if (vq[k].ev) begin
                chk($sformatf("vec%0d_pc", k), 32'(out_pc), 32'(vq[k].epc));
                chk($sformatf("vec%0d_instr", k), out_instr, instr_of(vq[k].epc));
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        // Full run with out_ready high: pcs 0..39 back-to-back, then halt.
        do_reset();
        for (int c = 0; c < 46; c++) begin
            chk($sformatf("run%0d_valid", c), 32'(out_valid), 32'((c >= 2 && c <= 41) ? 1 : 0));
            if (c >= 2 && c <= 41) begin
                chk($sformatf("run%0d_pc", c), 32'(out_pc), 32'(c - 2));
                chk($sformatf("run%0d_instr", c), out_instr, instr_of(11'(c - 2)));
            end
            chk($sformatf("run%0d_addr", c), 32'(imem_addr), 32'((c < 40) ? c : 40));
            chk($sformatf("run%0d_halted", c), 32'(halted), 32'((c >= 43) ? 1 : 0));
            @(negedge clk);
        end

        // Redirect past MEM_DEPTH mid-stream, then restart from HALT.
        do_reset();
        repeat (4) @(negedge clk);
        chk("oor_c4_pc", 32'(out_pc), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 11'd45;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("oor_c5_valid", 32'(out_valid), 32'd0);
        chk("oor_c5_addr", 32'(imem_addr), 32'd45);
        chk("oor_c5_halted", 32'(halted), 32'd0);
        @(negedge clk);
        chk("oor_c6_halted", 32'(halted), 32'd1);
        chk("oor_c6_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("oor_c7_halted", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 11'd3;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("resume_c8_halted", 32'(halted), 32'd0);
        chk("resume_c8_addr", 32'(imem_addr), 32'd3);
        chk("resume_c8_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("resume_c9_valid", 32'(out_valid), 32'd0);
        chk("resume_c9_addr", 32'(imem_addr), 32'd4);
        @(negedge clk);
        chk("resume_c10_valid", 32'(out_valid), 32'd1);
        chk("resume_c10_pc", 32'(out_pc), 32'd3);
        chk("resume_c10_instr", out_instr, instr_of(11'd3));
        @(negedge clk);
        chk("resume_c11_pc", 32'(out_pc), 32'd4);

        // Asynchronous reset between clock edges, then restart from pc 0.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_pc", 32'(out_pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_c0_addr", 32'(imem_addr), 32'd0);
        chk("rst2_c0_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst2_c2_valid", 32'(out_valid), 32'd1);
        chk("rst2_c2_pc", 32'(out_pc), 32'd0);
        chk("rst2_c2_instr", out_instr, instr_of(11'd0));
        @(negedge clk);
        chk("rst2_c3_pc", 32'(out_pc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
